// File: rtl/ifetch_unit_pkg.sv
// Shared rvcore fetch definitions: datapath widths, default reset vector and the
// {pc, ir} entry layout buffered between instruction memory and the decoder.
package ifetch_unit_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] ir;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_sync_fifo.sv
// Small synchronous FIFO with flush; pointers wrap modulo DEPTH (a power of two)
// and the occupancy count is exported so the fetch unit can meter its requests.
module sync_fifo
    import ifetch_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop    = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The requester's credit scheme guarantees a free slot for every response.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush) begin
            assert (!(push && count == FULL))
                else $error("sync_fifo overflow");
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: sequential PC generation, credit-limited memory
// requests, an in-order {pc, ir} buffer toward the decoder, and redirect handling.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int              DEPTH        = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [ILEN-1:0] imem_rsp_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [ILEN-1:0] if_ir_o,
    output logic [XLEN-1:0] if_pc_o
);

    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            rsp_fire;
    logic            push;
    logic            pop;
    fetch_entry_t    head;

    // Request eligibility looks only at registered state, never at redirect_i.
    assign credit_used      = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid_o = credit_used < (CW+1)'(DEPTH);
    assign imem_req_addr_o  = fetch_pc;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    assign rsp_fire         = imem_rsp_valid_i;
    assign push             = rsp_fire && (drop_cnt == '0) && !redirect_i;
    assign pop              = if_valid_o && if_ready_i && !redirect_i;
    assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_fire);

    // A redirect turns every request still in flight, including one accepted
    // this cycle, into a response that must be thrown away.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc    <= RESET_VECTOR;
            rsp_pc      <= RESET_VECTOR;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_i) begin
                fetch_pc <= word_align(redirect_pc_i);
                rsp_pc   <= word_align(redirect_pc_i);
                drop_cnt <= outstanding_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (rsp_fire && drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH(XLEN + ILEN),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush     (redirect_i),
        .push      (push),
        .push_data ({rsp_pc, imem_rsp_data_i}),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

    assign if_valid_o = (count != '0);
    assign if_pc_o    = head.pc;
    assign if_ir_o    = head.ir;

endmodule
